// File: rtl/display_smg_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_smg_mux
// Brief    : Multiplexed seven-segment driver. Scans DIGITS hex nibbles onto
//            shared digit/segment pins. Shows one of CH data pages, either
//            auto-rotated on a frame timer or manually selected. The page is
//            snapshotted once per scan frame so the display never tears.
//            Includes leading-zero blanking, a page-indicator decimal point
//            and a display enable.
// Revision : 1.0 - initial release
// ============================================================================
module display_smg_mux #(
    parameter int DIGITS      = 4,
    parameter int CH          = 2,
    parameter int SCAN_DIV    = 25000,
    parameter int PAGE_FRAMES = 2000,
    localparam int PW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                     clk_100MHz,
    input  logic                     rst,
    input  logic [CH*4*DIGITS-1:0]   ch_data,
    input  logic                     auto_mode,
    input  logic [PW-1:0]            page_sel,
    input  logic                     lz_blank,
    input  logic                     disp_en,
    output logic [DIGITS-1:0]        sm_wei,
    output logic [7:0]               sm_duan,
    output logic [PW-1:0]            page
);

    localparam int DATA_W = 4 * DIGITS;
    localparam int SW     = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int DW     = (DIGITS > 1)      ? $clog2(DIGITS)      : 1;
    localparam int FW     = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(PAGE_FRAMES - 1);
    localparam logic [PW-1:0] PAGE_LAST  = PW'(CH - 1);

    logic [SW-1:0]     presc;
    logic [DW-1:0]     digit;
    logic [FW-1:0]     frame_cnt;
    logic [DATA_W-1:0] snapshot;

    logic              scan_tick;
    logic              frame_end;
    logic [PW-1:0]     page_next;
    logic [FW-1:0]     frame_next;
    logic [DATA_W-1:0] page_data;
    logic [DIGITS-1:0] upper_zero;
    logic [3:0]        nibble;
    logic              blank;
    logic              dp_here;
    logic [7:0]        seg;
    logic [DIGITS-1:0] wei_next;

    // Hex digit to {g,f,e,d,c,b,a}, segments active-high.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign scan_tick = (presc == SCAN_LAST);
    assign frame_end = scan_tick && (digit == DIGIT_LAST);

    // Prescaler: one scan_tick every SCAN_DIV clocks.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst)
            presc <= '0;
        else if (scan_tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    // Digit index advances on each scan tick, wrapping after the last digit.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst)
            digit <= '0;
        else if (scan_tick)
            digit <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
    end

    // Next page / frame count, only moving at a frame boundary.
    always_comb begin
        page_next  = page;
        frame_next = frame_cnt;
        if (frame_end) begin
            if (auto_mode) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_next = '0;
                    page_next  = (page == PAGE_LAST) ? '0 : page + 1'b1;
                end else begin
                    frame_next = frame_cnt + 1'b1;
                end
            end else begin
                // Manual mode keeps the counter at 0 so auto mode starts fresh.
                frame_next = '0;
                page_next  = (page_sel > PAGE_LAST) ? PAGE_LAST : page_sel;
            end
        end
    end

    // Data slice of the page that will be current after this edge.
    always_comb begin
        page_data = '0;
        for (int p = 0; p < CH; p++) begin
            if (page_next == PW'(p))
                page_data = ch_data[p*DATA_W +: DATA_W];
        end
    end

    // Page, frame counter and snapshot all update together at frame end.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            page      <= '0;
            frame_cnt <= '0;
            snapshot  <= '0;
        end else begin
            page      <= page_next;
            frame_cnt <= frame_next;
            if (frame_end)
                snapshot <= page_data;
        end
    end

    // upper_zero[k]: nibbles k..DIGITS-1 of the snapshot are all zero.
    for (genvar k = 0; k < DIGITS; k++) begin : g_upper_zero
        assign upper_zero[k] = ~|snapshot[DATA_W-1:4*k];
    end

    // Decode the digit currently being scanned, with blanking and page dp.
    always_comb begin
        nibble   = '0;
        blank    = 1'b0;
        dp_here  = 1'b0;
        wei_next = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (int'(digit) == k) begin
                nibble      = snapshot[k*4 +: 4];
                blank       = lz_blank && (k != 0) && upper_zero[k];
                dp_here     = (int'(page) == k);
                wei_next[k] = 1'b1;
            end
        end
        seg = blank ? 8'h00 : {dp_here, hex7(nibble)};
    end

    // Registered pin drivers; disp_en darkens pins without stalling the scan.
    always_ff @(posedge clk_100MHz or negedge rst) begin
        if (!rst) begin
            sm_wei  <= '0;
            sm_duan <= '0;
        end else begin
            sm_wei  <= disp_en ? wei_next : '0;
            sm_duan <= disp_en ? seg : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_smg_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_display_smg_mux
// Brief    : Scoreboard bench for display_smg_mux (DIGITS=4, CH=2,
//            SCAN_DIV=4, PAGE_FRAMES=3). Expectations are queued with the
//            clock-edge index (counted from reset release) at which the pins
//            must hold them; a monitor compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_display_smg_mux;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ch_data = '0;
    logic        auto_mode = 1'b0;
    logic        page_sel = 1'b0;
    logic        lz_blank = 1'b0;
    logic        disp_en = 1'b1;
    logic [3:0]  sm_wei;
    logic [7:0]  sm_duan;
    logic        page;

    display_smg_mux #(
        .DIGITS      (4),
        .CH          (2),
        .SCAN_DIV    (4),
        .PAGE_FRAMES (3)
    ) dut (
        .clk_100MHz (clk),
        .rst        (rst),
        .ch_data    (ch_data),
        .auto_mode  (auto_mode),
        .page_sel   (page_sel),
        .lz_blank   (lz_blank),
        .disp_en    (disp_en),
        .sm_wei     (sm_wei),
        .sm_duan    (sm_duan),
        .page       (page)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at_edge;
        logic [3:0] wei;
        logic [7:0] duan;
        logic       pg;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    bit   flushed = 1'b0;

    // Rising edges since reset release; cleared asynchronously with the DUT.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            edge_n <= 0;
        else
            edge_n <= edge_n + 1;
    end

    // Monitor: pop every expectation due at this edge and compare.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
            cur = sb.pop_front();
            checks++;
            if (cur.at_edge < edge_n) begin
                errors++;
                $display("FAIL %s: check at edge %0d missed, now at edge %0d",
                         cur.name, cur.at_edge, edge_n);
            end else if (sm_wei !== cur.wei || sm_duan !== cur.duan || page !== cur.pg) begin
                errors++;
                $display("FAIL %s @%0d: sm_wei=%b sm_duan=%h page=%0d, required sm_wei=%b sm_duan=%h page=%0d",
                         cur.name, edge_n, sm_wei, sm_duan, page, cur.wei, cur.duan, cur.pg);
            end
        end
        if (done && !flushed) begin
            while (sb.size() > 0) begin
                cur = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: never checked (due edge %0d)", cur.name, cur.at_edge);
            end
            flushed = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic expect_at(input int at, input logic [3:0] w, input logic [7:0] s,
                             input logic p, input string nm);
        exp_t e;
        e.at_edge = at;
        e.wei     = w;
        e.duan    = s;
        e.pg      = p;
        e.name    = nm;
        sb.push_back(e);
    endtask

    // Returns 2 time units after rising edge number e.
    task automatic wait_edge(input int e);
        int guard;
        guard = 0;
        while (edge_n < e) begin
            if (guard > 1000) begin
                $display("FAIL wait_edge: stuck at edge %0d waiting for %0d", edge_n, e);
                $fatal(1);
            end
            @(posedge clk);
            #2;
            guard++;
        end
    endtask

    task automatic start_run(input logic [31:0] data, input logic am, input logic ps,
                             input logic lz, input logic en);
        @(posedge clk);
        #2;
        rst       = 1'b0;
        ch_data   = data;
        auto_mode = am;
        page_sel  = ps;
        lz_blank  = lz;
        disp_en   = en;
        expect_at(0, 4'b0000, 8'h00, 1'b0, "reset_hold");
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
    endtask

    initial begin
        // Manual scan of page 0 = 1234.
        start_run({16'hABCD, 16'h1234}, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_at(1,  4'b0001, 8'hBF, 1'b0, "release_first");
        expect_at(5,  4'b0010, 8'h3F, 1'b0, "frame0_digit1");
        expect_at(17, 4'b0001, 8'hE6, 1'b0, "scan_d0");
        expect_at(20, 4'b0001, 8'hE6, 1'b0, "scan_d0_hold");
        expect_at(21, 4'b0010, 8'h4F, 1'b0, "scan_d1");
        expect_at(25, 4'b0100, 8'h5B, 1'b0, "scan_d2");
        expect_at(29, 4'b1000, 8'h06, 1'b0, "scan_d3");
        expect_at(33, 4'b0001, 8'hE6, 1'b0, "scan_repeat");
        wait_edge(34);

        // Auto rotation every 3 frames (48 clocks).
        start_run({16'hABCD, 16'h1234}, 1'b1, 1'b0, 1'b0, 1'b1);
        expect_at(47, 4'b1000, 8'h06, 1'b0, "auto_pre_switch");
        expect_at(48, 4'b1000, 8'h06, 1'b1, "auto_page1");
        expect_at(49, 4'b0001, 8'h5E, 1'b1, "auto_p1_d0");
        expect_at(53, 4'b0010, 8'hB9, 1'b1, "auto_p1_d1_dp");
        expect_at(61, 4'b1000, 8'h77, 1'b1, "auto_p1_d3");
        expect_at(95, 4'b1000, 8'h77, 1'b1, "auto_p1_last");
        expect_at(96, 4'b1000, 8'h77, 1'b0, "auto_page0");
        expect_at(97, 4'b0001, 8'hE6, 1'b0, "auto_p0_d0");
        wait_edge(98);

        // Blanking, tearing, manual page, enable, mid-frame reset.
        start_run({16'hABCD, 16'h0070}, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_at(1,  4'b0001, 8'hBF, 1'b0, "lz_zero_d0");
        expect_at(5,  4'b0010, 8'h00, 1'b0, "lz_zero_d1");
        expect_at(17, 4'b0001, 8'hBF, 1'b0, "lz70_d0");
        expect_at(21, 4'b0010, 8'h07, 1'b0, "lz70_d1");
        expect_at(25, 4'b0100, 8'h00, 1'b0, "lz70_d2");
        expect_at(29, 4'b1000, 8'h00, 1'b0, "lz70_d3");
        wait_edge(30);
        lz_blank = 1'b0;
        expect_at(31, 4'b1000, 8'h3F, 1'b0, "nolz_d3");
        expect_at(41, 4'b0100, 8'h3F, 1'b0, "nolz_d2");
        wait_edge(41);
        ch_data[15:0] = 16'h1234;
        expect_at(49, 4'b0001, 8'hE6, 1'b0, "tear_new_d0");
        expect_at(53, 4'b0010, 8'h4F, 1'b0, "tear_d1");
        wait_edge(53);
        ch_data[15:0] = 16'h5678;
        expect_at(57, 4'b0100, 8'h5B, 1'b0, "tear_hold_d2");
        expect_at(61, 4'b1000, 8'h06, 1'b0, "tear_hold_d3");
        expect_at(65, 4'b0001, 8'hFF, 1'b0, "tear_next_d0");
        expect_at(69, 4'b0010, 8'h07, 1'b0, "tear_next_d1");
        expect_at(73, 4'b0100, 8'h7D, 1'b0, "tear_next_d2");
        expect_at(77, 4'b1000, 8'h6D, 1'b0, "tear_next_d3");
        wait_edge(77);
        page_sel = 1'b1;
        expect_at(80, 4'b1000, 8'h6D, 1'b1, "manual_page1");
        expect_at(81, 4'b0001, 8'h5E, 1'b1, "manual_p1_d0");
        expect_at(85, 4'b0010, 8'hB9, 1'b1, "manual_p1_d1");
        wait_edge(86);
        disp_en   = 1'b0;
        auto_mode = 1'b1;
        expect_at(87,  4'b0000, 8'h00, 1'b1, "dark_start");
        expect_at(100, 4'b0000, 8'h00, 1'b1, "dark_mid");
        expect_at(127, 4'b0000, 8'h00, 1'b1, "dark_pre_rotate");
        expect_at(128, 4'b0000, 8'h00, 1'b0, "dark_rotated");
        wait_edge(130);
        disp_en = 1'b1;
        expect_at(131, 4'b0001, 8'hFF, 1'b0, "enable_again");
        wait_edge(131);
        auto_mode = 1'b0;
        page_sel  = 1'b1;
        expect_at(144, 4'b1000, 8'h6D, 1'b1, "manual_again");
        expect_at(146, 4'b0001, 8'h5E, 1'b1, "pre_reset");
        wait_edge(147);
        rst = 1'b0;
        expect_at(0, 4'b0000, 8'h00, 1'b0, "midframe_reset");
        @(negedge clk);
        #1;
        done = 1'b1;
        for (int i = 0; i < 5 && !flushed; i++)
            @(negedge clk);
        #1;
        if (!flushed) begin
            $display("FAIL flush: scoreboard not drained");
            $fatal(1);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
